// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode-class helpers for the nibble-serial ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Ops that compute A-B through the adder (B inverted, carry-in of 1 on nibble 0)
  function automatic logic op_inverts_b(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT) || (op == OP_EQ);
  endfunction

  // Ops that use the carry chain at all
  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_ADD) || op_inverts_b(op);
  endfunction

endpackage

// File: rtl/alu4_slice.sv
// Combinational 4-bit ALU slice; one nibble of the operation per use.
module alu4_slice
  import alu_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout,
  output logic       ovf
);

  logic [3:0] b_eff;
  logic [4:0] sum;
  logic [3:0] low_sum;

  // Adder path for arithmetic ops, bitwise path for logic ops
  always_comb begin
    b_eff   = op_inverts_b(op) ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
    // Carry into bit 3 is needed for the signed-overflow term
    low_sum = {1'b0, a[2:0]} + {1'b0, b_eff[2:0]} + {3'b000, cin};
    y       = sum[3:0];
    cout    = 1'b0;
    ovf     = 1'b0;
    case (op)
      OP_NOT: y = ~a;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      default: begin
        y    = sum[3:0];
        cout = sum[4];
        ovf  = low_sum[3] ^ sum[4];
      end
    endcase
  end

endmodule

// File: rtl/alu_seq8.sv
// Nibble-serial ALU sequencer: accepts a W-bit request, runs it LSB nibble first through
// one 4-bit slice, and returns the registered result and flags on a valid/ready channel.
module alu_seq8
  import alu_pkg::*;
#(
  parameter int unsigned NIBBLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_carry,
  output logic                 rsp_overflow
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IDXW = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            zero_q, zero_d;
  logic            cflag_q, cflag_d;
  logic            vflag_q, vflag_d;

  logic [IDXW+1:0] nib_sel;
  logic [3:0]      a_nib, b_nib, y_nib;
  logic            slice_cin, slice_cout, slice_ovf;
  logic [W-1:0]    merged;
  logic [W-1:0]    final_res;

  // Select the current nibble and the carry-in for it
  always_comb begin
    nib_sel   = {idx_q, 2'b00};
    a_nib     = a_q[nib_sel +: 4];
    b_nib     = b_q[nib_sel +: 4];
    slice_cin = (idx_q == '0) ? op_inverts_b(op_q) : carry_q;
  end

  alu4_slice u_slice (
    .op   (op_q),
    .a    (a_nib),
    .b    (b_nib),
    .cin  (slice_cin),
    .y    (y_nib),
    .cout (slice_cout),
    .ovf  (slice_ovf)
  );

  // Insert the slice output into the result and form the remapped final value
  always_comb begin
    merged               = result_q;
    merged[nib_sel +: 4] = y_nib;
    case (op_q)
      OP_SLT:  final_res = {{(W - 1){1'b0}}, y_nib[3] ^ slice_ovf};
      OP_EQ:   final_res = {{(W - 1){1'b0}}, merged == '0};
      default: final_res = merged;
    endcase
  end

  // Next-state logic for the FSM and all datapath registers
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    zero_d   = zero_q;
    cflag_d  = cflag_q;
    vflag_d  = vflag_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          idx_d   = '0;
          carry_d = 1'b0;
          zero_d  = 1'b0;
          cflag_d = 1'b0;
          vflag_d = 1'b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = merged;
        carry_d  = slice_cout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          result_d = final_res;
          zero_d   = (final_res == '0);
          // Final carry-out is reported as-is for add and inverted (borrow) for A-B ops
          cflag_d  = op_is_arith(op_q) & (slice_cout ^ op_inverts_b(op_q));
          vflag_d  = ((op_q == OP_ADD) || (op_q == OP_SUB)) & slice_ovf;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cflag_q  <= 1'b0;
      vflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cflag_q  <= cflag_d;
      vflag_q  <= vflag_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_result   = result_q;
  assign rsp_zero     = zero_q;
  assign rsp_carry    = cflag_q;
  assign rsp_overflow = vflag_q;

endmodule
